// File: rtl/vga_sync_decoder.sv
// Recovers line/frame timing, lock status and pixel coordinates from an active-low hsync/vsync pair.
// Define VGA_SYNC_DEC_LOS_EN to drop lock and clear the measured totals when a counter saturates.
module vga_sync_decoder #(
    parameter int H_START     = 167,
    parameter int H_ACTIVE    = 640,
    parameter int V_START     = 32,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       px_clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] x_px,
    output logic [9:0] y_px,
    output logic       activevideo,
    output logic [9:0] h_total,
    output logic [9:0] v_total,
    output logic       locked,
    output logic       frame_start
);
    localparam logic [9:0]  CNT_MAX = 10'h3FF;
    localparam logic [9:0]  H_OFS   = 10'(H_START);
    localparam logic [9:0]  V_OFS   = 10'(V_START);
    localparam logic [10:0] H_END   = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V_END   = 11'(V_START + V_ACTIVE);
    localparam logic [4:0]  LOCK_N  = 5'(LOCK_FRAMES);

    logic       hs_q, vs_q;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic [9:0] h_total_q, h_total_d;
    logic [9:0] v_total_q, v_total_d;
    logic       h_stable_q, h_stable_d;
    logic [3:0] match_cnt_q, match_cnt_d;
    logic       locked_q, locked_d;
    logic [9:0] x_px_q, x_px_d;
    logic [9:0] y_px_q, y_px_d;
    logic       active_q, active_d;
    logic       frame_start_q, frame_start_d;

    logic       hs_e, vs_e, match, in_window, los;
    logic [9:0] h_len;

`ifdef VGA_SYNC_DEC_LOS_EN
    assign los = (hcnt_q == CNT_MAX) || (vcnt_q == CNT_MAX);
`else
    assign los = 1'b0;
`endif

    always_comb begin
        hs_e          = hs_q & ~hsync;
        vs_e          = vs_q & ~vsync;
        h_len         = hcnt_q + 10'd1;
        match         = (vcnt_q == v_total_q) && h_stable_q;
        in_window     = ({1'b0, hcnt_q} >= {1'b0, H_OFS}) && ({1'b0, hcnt_q} < H_END) &&
                        ({1'b0, vcnt_q} >= {1'b0, V_OFS}) && ({1'b0, vcnt_q} < V_END);

        hcnt_d        = (hcnt_q == CNT_MAX) ? hcnt_q : h_len;
        vcnt_d        = vcnt_q;
        h_total_d     = h_total_q;
        v_total_d     = v_total_q;
        h_stable_d    = h_stable_q;
        match_cnt_d   = match_cnt_q;
        locked_d      = locked_q;
        x_px_d        = hcnt_q - H_OFS;
        y_px_d        = vcnt_q - V_OFS;
        active_d      = locked_q & in_window;
        frame_start_d = vs_e;

        if (hs_e) begin
            hcnt_d    = '0;
            h_total_d = h_len;
            if (h_len != h_total_q)
                h_stable_d = 1'b0;
            if (vcnt_q != CNT_MAX)
                vcnt_d = vcnt_q + 10'd1;
        end

        // The frame edge takes priority over a coincident line edge, so a fresh frame starts at line 0.
        if (vs_e) begin
            vcnt_d = '0;
            if (match) begin
                if ({1'b0, match_cnt_q} < LOCK_N)
                    match_cnt_d = match_cnt_q + 4'd1;
                if (({1'b0, match_cnt_q} + 5'd1) >= LOCK_N)
                    locked_d = 1'b1;
            end else begin
                match_cnt_d = '0;
                locked_d    = 1'b0;
            end
            v_total_d  = vcnt_q;
            h_stable_d = 1'b1;
        end

        if (los) begin
            locked_d    = 1'b0;
            match_cnt_d = '0;
            h_total_d   = '0;
            v_total_d   = '0;
            h_stable_d  = 1'b1;
            active_d    = 1'b0;
        end
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            h_stable_q    <= 1'b1;
            match_cnt_q   <= '0;
            locked_q      <= 1'b0;
            x_px_q        <= '0;
            y_px_q        <= '0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hs_q          <= hsync;
            vs_q          <= vsync;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            h_stable_q    <= h_stable_d;
            match_cnt_q   <= match_cnt_d;
            locked_q      <= locked_d;
            x_px_q        <= x_px_d;
            y_px_q        <= y_px_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x_px        = x_px_q;
    assign y_px        = y_px_q;
    assign activevideo = active_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Recovers video timing from an incoming VGA-style hsync/vsync pair on the pixel clock. It measures line and frame length, declares lock once timing has been stable for a configurable number of frames, and regenerates pixel coordinates and an active-video flag. It sits at the receiving end of the sync generator output, for example in a capture/overlay path or as a loopback checker for the display pipeline.

## Interface
- H_START, 167: hcnt value of the first active pixel in a line.
- H_ACTIVE, 640: active pixels per line.
- V_START, 32: vcnt value of the first active line.
- V_ACTIVE, 480: active lines per frame.
- LOCK_FRAMES, 2: consecutive matching frames required to assert lock (1..15).
- px_clk  in  1  pixel clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- hsync  in  1  horizontal sync, active low, synchronous to px_clk.
- vsync  in  1  vertical sync, active low, synchronous to px_clk.
- x_px  out  10  recovered column.
- y_px  out  10  recovered line.
- activevideo  out  1  high inside the active window while locked.
- h_total  out  10  last measured line length in cycles.
- v_total  out  10  last measured frame length in lines.
- locked  out  1  timing stable.
- frame_start  out  1  one-cycle pulse on each vsync active edge.

## Operation
- hs_q/vs_q: previous samples of hsync/vsync, reset to 1.
- hsync edge (hs_e) = hs_q & ~hsync. vsync edge (vs_e) = vs_q & ~vsync.
- hcnt (10b): 0 on hs_e, otherwise +1, saturating at 1023.
- On hs_e: h_total <= hcnt+1 (10b). If hcnt+1 != h_total (old value), clear h_stable.
- vcnt (10b): on vs_e <= 0. Else on hs_e +1, saturating at 1023. If vs_e and hs_e occur together, vs_e wins and vcnt = 0.
- On vs_e, lock evaluation:
  - match = (vcnt == v_total) & h_stable.
  - If match, match_cnt increments, saturating at LOCK_FRAMES. Otherwise match_cnt <= 0 and locked <= 0.
  - locked <= 1 once match_cnt+1 >= LOCK_FRAMES with match true.
  - Then v_total <= vcnt, h_stable <= 1.
- Every cycle, registered from pre-edge hcnt/vcnt:
  - x_px <= hcnt - H_START (mod 1024).
  - y_px <= vcnt - V_START (mod 1024).
  - activevideo <= locked & (H_START <= hcnt < H_START+H_ACTIVE) & (V_START <= vcnt < V_START+V_ACTIVE).
- frame_start <= vs_e.
- Reset values: all counters, h_total, v_total, x_px, y_px, activevideo, locked, frame_start, match_cnt = 0; h_stable = 1.

## Timing
- Edge detection latency: hcnt = 0 in the cycle after the first low sample of hsync.
- x_px, y_px and activevideo lag hcnt/vcnt by one cycle. activevideo rises the cycle after hcnt == H_START.
- frame_start is high in the cycle after the first low sample of vsync.
- locked changes only at vs_e (the loss-of-signal path below is the exception).
- Lock delay: locked rises at vs_e number LOCK_FRAMES+1 after reset, given clean input. The first frame's v_total is invalid.
- Reset mid-frame: everything clears immediately. Relock takes the same count as from power-up.

## Configuration
- VGA_SYNC_DEC_LOS_EN: loss-of-signal detection.
- With it defined: if hcnt reaches 1023, or vcnt reaches 1023, then in the next cycle locked, match_cnt, h_total, v_total and activevideo clear to 0, and h_stable is set to 1. They stay cleared until normal evaluation resumes.
- Without it: the counters saturate silently. locked holds its value until the next vs_e evaluation.

## Test plan
- Generator timing (832×520, hsync low 40, vsync low 3 lines), LOCK_FRAMES=2 -> h_total=832, v_total=520; locked rises at the 3rd vs_e; frame_start pulses every 432640 cycles.
- Locked and steady -> activevideo high exactly 640 cycles per line on 480 lines; x_px runs 0..639 and y_px 0..479 during activevideo.
- After lock, one line shortened to 831 cycles -> h_total=831 then 832; locked drops at the next vs_e; relocks 2 frames later.
- reset asserted mid-frame while locked -> all outputs 0 asynchronously; locked re-asserts at the 3rd vs_e after release.
- hsync and vsync held high for 2000 cycles with VGA_SYNC_DEC_LOS_EN -> locked and h_total read 0 after hcnt reaches 1023. Without the macro -> locked stays 1.
- vsync edge in the same cycle as hsync edge -> vcnt = 0, not 1; v_total equals the previous line count.
